// File: rtl/conbus_pack.sv
// ============================================================================
// Module      : conbus_pack
// Description : Shared types, defaults and helpers for the conbus fabric.
// Revision    : 1.0 - round-robin arbiter support
// ============================================================================
`default_nettype none

package conbus_pack;

    localparam int dw = 32;
    localparam int aw = 32;
    localparam int sw = dw / 8;

    localparam int N_MST_DEFAULT   = 4;
    localparam int TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        TERR  = 2'd2
    } arb_state_t;

    // Watchdog counter width; kept at least 1 bit so a disabled watchdog still elaborates.
    function automatic int wdog_w(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conbus_rr_picker.sv
// ============================================================================
// Module      : conbus_rr_picker
// Description : Combinational round-robin pick: first requester above ptr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conbus_rr_picker
    import conbus_pack::*;
#(
    parameter int N_MST = N_MST_DEFAULT,
    parameter int IW    = $clog2(N_MST)
) (
    input  logic [N_MST-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_MST-1:0] gnt,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    always_comb begin
        int j;
        j     = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        // Scan ptr+1 .. ptr+N_MST so the last grantee has lowest priority.
        for (int k = 1; k <= N_MST; k++) begin
            j = (int'(ptr) + k) % N_MST;
            if (!valid && req[j]) begin
                valid  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/conbus_rr_arbiter.sv
// ============================================================================
// Module      : conbus_rr_arbiter
// Description : N-master to 1-slave Wishbone round-robin arbiter with watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conbus_rr_arbiter
    import conbus_pack::*;
#(
    parameter int N_MST   = N_MST_DEFAULT,
    parameter int DW      = dw,
    parameter int AW      = aw,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [N_MST-1:0]  m_cyc_i,
    input  logic [N_MST-1:0]  m_stb_i,
    input  logic [N_MST-1:0]  m_we_i,
    input  logic [N_MST-1:0]  m_cab_i,
    input  logic [N_MST*AW-1:0] m_adr_i,
    input  logic [N_MST*DW-1:0] m_dat_i,
    input  logic [N_MST*SW-1:0] m_sel_i,
    output logic [DW-1:0]     m_dat_o,
    output logic [N_MST-1:0]  m_ack_o,
    output logic [N_MST-1:0]  m_err_o,
    output logic [N_MST-1:0]  m_rty_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic              s_cab_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic [SW-1:0]     s_sel_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    input  logic              s_rty_i,
    output logic [N_MST-1:0]  gnt_o,
    output logic              timeout_o
);

    localparam int IW = $clog2(N_MST);
    localparam int WW = wdog_w(TIMEOUT);

    arb_state_t       r_state, w_state_nxt;
    logic [N_MST-1:0] r_gnt, w_gnt_nxt, w_pick_gnt;
    logic [IW-1:0]    r_ptr, w_ptr_nxt, w_pick_idx;
    logic             w_pick_valid, w_owner_cyc, w_term, w_fire, w_rearb;

    assign w_owner_cyc = |(r_gnt & m_cyc_i);
    assign w_term      = s_ack_i | s_err_i | s_rty_i;

    conbus_rr_picker #(.N_MST(N_MST)) u_picker (
        .req   (m_cyc_i),
        .ptr   (r_ptr),
        .gnt   (w_pick_gnt),
        .idx   (w_pick_idx),
        .valid (w_pick_valid)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        w_rearb     = 1'b0;
        case (r_state)
            IDLE:    w_rearb = 1'b1;
            OWNED: begin
                if (!w_owner_cyc)  w_rearb = 1'b1;
                else if (w_fire)   w_state_nxt = TERR;
            end
            TERR: begin
                if (w_owner_cyc)   w_state_nxt = OWNED;
                else               w_rearb = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
        if (w_rearb) begin
            if (w_pick_valid) begin
                w_state_nxt = OWNED;
                w_gnt_nxt   = w_pick_gnt;
                w_ptr_nxt   = w_pick_idx;
            end else begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_ptr   <= IW'(N_MST - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // One-hot grant makes an AND-OR mux; an idle bus drives zeros.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        for (int i = 0; i < N_MST; i++) begin
            s_adr_o = s_adr_o | ({AW{r_gnt[i]}} & m_adr_i[i*AW +: AW]);
            s_dat_o = s_dat_o | ({DW{r_gnt[i]}} & m_dat_i[i*DW +: DW]);
            s_sel_o = s_sel_o | ({SW{r_gnt[i]}} & m_sel_i[i*SW +: SW]);
        end
    end

    assign s_cyc_o = w_owner_cyc;
    assign s_stb_o = (r_state == OWNED) & |(r_gnt & m_stb_i);
    assign s_we_o  = |(r_gnt & m_we_i);
    assign s_cab_o = |(r_gnt & m_cab_i);

    assign m_dat_o = s_dat_i;
    assign gnt_o   = r_gnt;
    assign m_ack_o = (r_state == OWNED) ? (r_gnt & {N_MST{s_ack_i}}) : '0;
    assign m_rty_o = (r_state == OWNED) ? (r_gnt & {N_MST{s_rty_i}}) : '0;
    assign m_err_o = (r_state == TERR)  ? r_gnt :
                     (r_state == OWNED) ? (r_gnt & {N_MST{s_err_i}}) : '0;

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam logic [WW-1:0] c_wdog_last = WW'(TIMEOUT - 1);
            logic [WW-1:0] r_wdog;
            logic          w_stall;

            assign w_stall   = s_cyc_o & s_stb_o & ~w_term;
            // Fire on the edge where the count would reach TIMEOUT; a termination wins.
            assign w_fire    = (r_state == OWNED) & w_stall & (r_wdog == c_wdog_last);
            assign timeout_o = (r_state == TERR);

            always_ff @(posedge clk_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    r_wdog <= '0;
                end else if ((r_state != OWNED) || !w_owner_cyc || w_term || w_fire) begin
                    r_wdog <= '0;
                end else if (w_stall) begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end
        end else begin : g_no_wdog
            assign w_fire    = 1'b0;
            assign timeout_o = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: doc/conbus_rr_arbiter.md
Name: conbus_rr_arbiter

Overview:
Parametrised N-master to 1-slave Wishbone classic arbiter for the conbus fabric.
- Grants the shared slave port to one master at a time, in round-robin order.
- Holds the grant for the whole cyc period of the owning master.
- Adds a stalled-transfer watchdog that terminates a hung access with err.
- Sits between the master-side conbus_interface instances and the address-decode stage.

Parameters:
N_MST, 4, number of masters (2..16)
DW, 32, data width
AW, 32, address width
SW, DW/8, byte-select width
TIMEOUT, 255, stalled cycles before forced err; 0 disables the watchdog

Ports:
clk_i  in  1  system clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
m_cyc_i  in  N_MST  per-master cyc
m_stb_i  in  N_MST  per-master stb
m_we_i  in  N_MST  per-master we
m_cab_i  in  N_MST  per-master cab
m_adr_i  in  N_MST*AW  packed addresses, master i at [i*AW +: AW]
m_dat_i  in  N_MST*DW  packed write data
m_sel_i  in  N_MST*SW  packed byte selects
m_dat_o  out  DW  read data, broadcast to all masters
m_ack_o  out  N_MST  per-master ack
m_err_o  out  N_MST  per-master err
m_rty_o  out  N_MST  per-master rty
s_cyc_o, s_stb_o, s_we_o, s_cab_o  out  1 each  slave control
s_adr_o  out  AW  slave address
s_dat_o  out  DW  slave write data
s_sel_o  out  SW  slave byte selects
s_dat_i  in  DW  slave read data
s_ack_i, s_err_i, s_rty_i  in  1 each  slave termination
gnt_o  out  N_MST  one-hot registered grant, 0 when idle
timeout_o  out  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset (async, rst_n_i=0):
  - gnt_o=0, state IDLE, watchdog count=0, last-grant pointer=N_MST-1 (so master 0 has highest priority first).
  - All s_*_o, m_ack/err/rty_o and timeout_o = 0. m_dat_o = s_dat_i (pass-through).
- State machine states: IDLE, OWNED, TERR.
- Arbitration:
  - Evaluated at each rising edge in IDLE, and in OWNED when the owner's m_cyc_i=0.
  - Winner = first requester (m_cyc_i=1) scanning upward from pointer+1, modulo N_MST.
  - Grant latency: request sampled at edge k, gnt_o valid after edge k.
  - Handover is gapless: the owner drops cyc and the next requester is granted at the same edge.
  - No requesters: go to IDLE, gnt_o=0. Pointer updates to the winner index on each new grant.
- While OWNED:
  - Grant is held while the owner's m_cyc_i=1, regardless of other requests.
  - Slave outputs are a combinational mux of the owner's inputs, gated by gnt_o: s_cyc_o = m_cyc_i[owner], s_stb_o = m_stb_i[owner] (forced 0 in TERR).
  - s_ack_i, s_err_i and s_rty_i are routed combinationally to the owner only. Non-owners always see 0.
- Watchdog (TIMEOUT>0):
  - Counter width = $clog2(TIMEOUT+1).
  - Increments each cycle with s_cyc_o & s_stb_o & !(s_ack_i|s_err_i|s_rty_i).
  - Clears on any termination, on grant change, and on leaving OWNED.
  - When the count equals TIMEOUT at an edge, enter TERR for exactly one cycle:
    - m_err_o[owner]=1 and timeout_o=1.
    - s_stb_o=0 and slave terminations are ignored.
    - Counter cleared.
  - TERR then goes to OWNED if the owner's cyc is still high, otherwise re-arbitrates as above.
- Boundaries:
  - Termination in the same cycle the count reaches TIMEOUT: the termination wins, no err, counter cleared.
  - Owner drops cyc in the same cycle as ack: ack is still delivered, then handover.
  - Requests arriving during TERR are not granted until TERR exits.
  - Reset asserted mid-transfer: outputs zero immediately, in-flight transfer abandoned.
  - TIMEOUT=0: counter and TERR are never used, timeout_o is tied to 0.

Decomposition:
- conbus_pack gains:
  - arb_state_t enum {IDLE, OWNED, TERR}
  - N_MST_DEFAULT and TIMEOUT_DEFAULT constants
  - function wdog_w(TIMEOUT) for the counter width
  - existing dw, aw and sw reused as DW/AW/SW defaults
- One sub-module: conbus_rr_picker.
  - Purely combinational: req[N_MST] plus pointer in, one-hot winner and index out.
  - Instanced once; all state and the datapath mux stay in the top.

Test Plan:
1. Reset; m_cyc_i=0001, read to 0x100; slave acks 2 cycles later with s_dat_i=0xDEADBEEF -> gnt_o=0001 one edge after request; m_ack_o=0001 for one cycle; m_dat_o=0xDEADBEEF; m_ack_o[3:1]=0.
2. m_cyc_i=1111, each master does one single-cycle-ack transfer then drops cyc -> grant order 0,1,2,3,0 with no idle cycle between grants.
3. Master 2 owns with a 6-cycle burst, master 0 requests at cycle 1 -> master 0 not granted until the edge where m_cyc_i[2] falls; gnt_o then 0001.
4. TIMEOUT=8, slave never terminates -> after 8 stalled cycles: one cycle of m_err_o[owner]=1, timeout_o=1, s_stb_o=0; then OWNED again with counter 0.
5. TIMEOUT=8, s_ack_i asserted on the 8th stalled cycle -> ack delivered to the owner; m_err_o=0; timeout_o=0.
6. rst_n_i pulsed low mid-transfer with master 3 owning; m_cyc_i=1001 after release -> all outputs 0 during reset; first grant after release gnt_o=0001.
